// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with the result presented on a valid/ready register-file write port.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      kill,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                funct3,
    input  logic [DATA_WIDTH-1:0]     rs1_data,
    input  logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      wb_we,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0]     wb_data
);
    localparam int unsigned W = DATA_WIDTH;
    localparam logic [5:0] LastStep = 6'(W - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                    state_q, state_d;
    logic [2:0]                op_q, op_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [W-1:0]              opnd_q, opnd_d;
    logic [W-1:0]              hi_q, hi_d;
    logic [W-1:0]              lo_q, lo_d;
    logic                      neg_q, neg_d;
    logic [5:0]                cnt_q, cnt_d;
    logic [W-1:0]              result_q, result_d;

    // Request decode: magnitudes, final sign and the RISC-V special cases.
    logic         is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic         div_zero_in, overflow_in, neg_in;
    logic [W-1:0] a_mag_in, b_mag_in, special_res;

    always_comb begin
        is_div_in   = funct3[2];
        a_signed_in = is_div_in ? ~funct3[0] : (funct3[1] ^ funct3[0]);
        b_signed_in = is_div_in ? ~funct3[0] : (funct3[1:0] == 2'b01);
        a_neg_in    = a_signed_in & rs1_data[W-1];
        b_neg_in    = b_signed_in & rs2_data[W-1];
        a_mag_in    = a_neg_in ? -rs1_data : rs1_data;
        b_mag_in    = b_neg_in ? -rs2_data : rs2_data;
        neg_in      = (is_div_in & funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
        div_zero_in = is_div_in & (rs2_data == '0);
        overflow_in = is_div_in & ~funct3[0] & (rs1_data == {1'b1, {(W-1){1'b0}}})
                      & (&rs2_data);
        if (div_zero_in) special_res = funct3[1] ? rs1_data : '1;
        else             special_res = funct3[1] ? '0 : rs1_data;
    end

    // One iteration step. Multiply keeps the multiplier in lo and shifts the product in from
    // the top; divide keeps the dividend/quotient in lo and the partial remainder in hi.
    logic [W:0]     mul_sum, mul_acc, div_shift, div_diff;
    logic           div_fits;
    logic [W-1:0]   hi_nxt, lo_nxt, div_sel, div_res, mul_res;
    logic [2*W-1:0] prod_abs, prod_fin;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, opnd_q};
        mul_acc   = lo_q[0] ? mul_sum : {1'b0, hi_q};
        div_shift = {hi_q, lo_q[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_fits  = ~div_diff[W];
        if (op_q[2]) begin
            hi_nxt = div_fits ? div_diff[W-1:0] : div_shift[W-1:0];
            lo_nxt = {lo_q[W-2:0], div_fits};
        end else begin
            hi_nxt = mul_acc[W:1];
            lo_nxt = {mul_acc[0], lo_q[W-1:1]};
        end
        prod_abs = {hi_nxt, lo_nxt};
        prod_fin = neg_q ? -prod_abs : prod_abs;
        mul_res  = (op_q[1:0] == 2'b00) ? prod_fin[W-1:0] : prod_fin[2*W-1:W];
        div_sel  = op_q[1] ? hi_nxt : lo_nxt;
        div_res  = neg_q ? -div_sel : div_sel;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (kill) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d  = funct3;
                        rd_d  = rd_addr;
                        neg_d = neg_in;
                        cnt_d = '0;
                        if (div_zero_in || overflow_in) begin
                            result_d = special_res;
                            state_d  = StDone;
                        end else begin
                            opnd_d  = is_div_in ? b_mag_in : a_mag_in;
                            hi_d    = '0;
                            lo_d    = is_div_in ? a_mag_in : b_mag_in;
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    hi_d  = hi_nxt;
                    lo_d  = lo_nxt;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LastStep) begin
                        result_d = op_q[2] ? div_res : mul_res;
                        state_d  = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            rd_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // kill suppresses the handshake in the same cycle so a flushed result is never written.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone) & ~kill;
        wb_we     = out_valid & out_ready & (rd_q != '0);
        wb_addr   = rd_q;
        wb_data   = result_q;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, special cases, stall, kill, reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        kill = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic        in_ready, out_valid, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .kill(kill), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_ready(out_ready), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data)
    );

    // Present a request for one cycle, then scramble the inputs after the accept edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        funct3 = f3; rs1_data = a; rs2_data = b; rd_addr = rd; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; funct3 = ~f3; rs1_data = 32'h5A5A_A5A5; rs2_data = 32'h0;
        rd_addr = ~rd;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_out(output logic we, output logic rdy);
        @(negedge clk); out_ready = 1'b1; #1; we = wb_we;
        @(posedge clk); #1; rdy = in_ready; out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL reset_wb_we got=%b exp=0", wb_we); end
        checks++; if (wb_addr !== 5'd0) begin failures++; $display("FAIL reset_wb_addr got=%h exp=0", wb_addr); end
        checks++; if (wb_data !== 32'd0) begin failures++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_arith(input string tag, input int n, input logic [2:0] f3s [11],
                              input logic [31:0] as [11], input logic [31:0] bs [11],
                              input logic [31:0] exps [11], input int lats [11]);
        int lat; logic we, rdy;
        for (int i = 0; i < n; i++) begin
            issue(f3s[i], as[i], bs[i], 5'(i + 1));
            wait_valid(lat);
            checks++; if (lat !== lats[i]) begin failures++; $display("FAIL %s_lat[%0d] got=%0d exp=%0d", tag, i, lat, lats[i]); end
            checks++; if (wb_data !== exps[i]) begin failures++; $display("FAIL %s_data[%0d] got=%h exp=%h", tag, i, wb_data, exps[i]); end
            checks++; if (wb_addr !== 5'(i + 1)) begin failures++; $display("FAIL %s_addr[%0d] got=%h exp=%h", tag, i, wb_addr, 5'(i + 1)); end
            release_out(we, rdy);
            checks++; if (we !== 1'b1) begin failures++; $display("FAIL %s_we[%0d] got=%b exp=1", tag, i, we); end
            checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL %s_ready[%0d] got=%b exp=1", tag, i, rdy); end
        end
    endtask

    task automatic test_multiply;
        logic [2:0]  f3s  [11] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b001, 3'b011, 3'b000,
                                   3'b000, 3'b000, 3'b000, 3'b000};
        logic [31:0] as   [11] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000, 0, 0, 0, 0};
        logic [31:0] bs   [11] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                   32'd5, 32'hFFFF_FFFF, 32'h0001_0000, 0, 0, 0, 0};
        logic [31:0] exps [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hC000_0000,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 0, 0, 0, 0};
        int          lats [11] = '{32, 32, 32, 32, 32, 32, 32, 0, 0, 0, 0};
        test_arith("mul", 7, f3s, as, bs, exps, lats);
    endtask

    task automatic test_divide;
        logic [2:0]  f3s  [11] = '{3'b100, 3'b110, 3'b101, 3'b110, 3'b111, 3'b101, 3'b100,
                                   3'b111, 3'b100, 3'b110, 3'b101};
        logic [31:0] as   [11] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'd100,
                                   32'h8000_0000, 32'h1234, 32'd5, 32'h8000_0000,
                                   32'h8000_0000, 32'h1234};
        logic [31:0] bs   [11] = '{32'd2, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFFF,
                                   32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exps [11] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1, 32'd2, 32'd0,
                                   32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        int          lats [11] = '{32, 32, 32, 32, 32, 32, 0, 0, 0, 0, 0};
        test_arith("div", 11, f3s, as, bs, exps, lats);
    endtask

    task automatic test_stall;
        int lat; int pulses; logic stable;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3);
        wait_valid(lat);
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!out_valid || wb_data !== 32'hFFFF_FFEB || wb_we || wb_addr !== 5'd3) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL stall_hold got=%b exp=1", stable); end
        @(negedge clk); out_ready = 1'b1; pulses = 0;
        repeat (3) begin
            #1; if (wb_we) pulses++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (pulses !== 1) begin failures++; $display("FAIL stall_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_kill;
        logic seen; int lat;
        issue(3'b100, 32'd100, 32'd7, 5'd4);
        repeat (10) @(posedge clk);
        @(negedge clk); kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL kill_calc_ready got=%b exp=1", in_ready); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL kill_calc_quiet got=%b exp=0", seen); end
        // Kill in DONE while writeback is ready: no write, result dropped.
        issue(3'b100, 32'd9, 32'd0, 5'd6);
        wait_valid(lat);
        @(negedge clk); kill = 1'b1; out_ready = 1'b1; #1;
        checks++; if (wb_we !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL kill_done_we got=%b/%b exp=0/0", wb_we, out_valid); end
        @(posedge clk); #1; kill = 1'b0; out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL kill_done_idle got=%b/%b exp=1/0", in_ready, out_valid); end
        // kill together with a request in IDLE: nothing accepted.
        @(negedge clk); kill = 1'b1; in_valid = 1'b1; funct3 = 3'b101; rs1_data = 32'd1; rs2_data = 32'd0; rd_addr = 5'd7;
        @(posedge clk); #1; kill = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        repeat (5) begin if (out_valid || !in_ready) seen = 1'b1; @(posedge clk); #1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL kill_idle_accept got=%b exp=0", seen); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
        repeat (10) @(posedge clk);
        @(negedge clk); #2; rst = 1'b0; #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got=%b/%b exp=1/0", in_ready, out_valid); end
        checks++; if (wb_data !== 32'd0 || wb_addr !== 5'd0) begin failures++; $display("FAIL rstmid_regs got=%h/%h exp=0/0", wb_data, wb_addr); end
        @(negedge clk); rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid || !in_ready) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_quiet got=%b exp=0", seen); end
    endtask

    task automatic test_rd_zero;
        int lat; logic we, rdy;
        issue(3'b000, 32'd2, 32'd3, 5'd0);
        wait_valid(lat);
        checks++; if (out_valid !== 1'b1 || wb_data !== 32'd6) begin failures++; $display("FAIL rd0_result got=%b/%h exp=1/00000006", out_valid, wb_data); end
        release_out(we, rdy);
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL rd0_we got=%b exp=0", we); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL rd0_ready got=%b exp=1", rdy); end
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(3'b000, 32'd3, 32'd4, 5'd1);
        wait_valid(lat);
        // Second request arrives while DONE is being released; it must wait one cycle.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; funct3 = 3'b101; rs1_data = 32'd7; rs2_data = 32'd2;
        rd_addr = 5'd2;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", in_ready); end
        @(posedge clk); #1; out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%b exp=1", in_ready); end
        @(posedge clk); #1; in_valid = 1'b0;
        wait_valid(lat);
        checks++; if (lat !== 32 || wb_data !== 32'd3 || wb_addr !== 5'd2) begin failures++; $display("FAIL b2b_second got=%0d/%h/%h exp=32/00000003/02", lat, wb_data, wb_addr); end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_multiply;
        test_divide;
        test_stall;
        test_kill;
        test_reset_mid;
        test_rd_zero;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
